// File: rtl/spi_pkg.sv
// Shared SPI types and mode-0 idle levels. The GAP state exists only when
// SPI_CTRL_BYTE_GAP_EN is defined.
package spi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StSckHi,
    StSckLo,
    StFinish
`ifdef SPI_CTRL_BYTE_GAP_EN
    , StGap
`endif
  } spi_state_e;

  localparam logic SckIdle  = 1'b0;
  localparam logic CsIdle   = 1'b1;
  localparam logic CopiIdle = 1'b0;

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period tick generator: tick_o pulses every CLKDIV cycles while en_i is high,
// restarting from zero whenever en_i drops.
module spi_clk_tick #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CntW'(CLKDIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tick_o) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 controller: little-endian bytes, MSB-first bits. Defining
// SPI_CTRL_BYTE_GAP_EN inserts a 2*CLKDIV idle gap between bytes.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned BITS   = 64,
  parameter int unsigned CLKDIV = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [BITS-1:0] tx_word,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] rx_word,
  output logic            SCK,
  output logic            CS,
  output logic            COPI,
  input  logic            CIPO
);

  localparam int unsigned CntW = $clog2(BITS);

  // Byte reversal turns little-endian byte order into one plain MSB-first shift.
  function automatic logic [BITS-1:0] byte_swap(input logic [BITS-1:0] w);
    logic [BITS-1:0] r;
    r = '0;
    for (int i = 0; i < int'(BITS / 8); i++) r[8*i +: 8] = w[BITS-8-8*i +: 8];
    return r;
  endfunction

  spi_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [BITS-1:0] tx_sr_q, rx_sr_q, rx_word_q;
  logic            done_q;
  logic            tick;
  logic            start_ok;
  logic            last_bit;
`ifdef SPI_CTRL_BYTE_GAP_EN
  logic            gap_half_q;
`endif

  spi_clk_tick #(
    .CLKDIV(CLKDIV)
  ) u_tick (
    .clk   (clk),
    .resetn(resetn),
    .en_i  (busy),
    .tick_o(tick)
  );

  // A start seen on the done cycle is dropped.
  assign start_ok = (state_q == StIdle) && start && !done_q;
  assign last_bit = (cnt_q == CntW'(BITS - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_ok) state_d = StSetup;
      StSetup:  if (tick) state_d = StSckHi;
      StSckHi:  if (tick) state_d = StSckLo;
      StSckLo: begin
        if (tick) begin
          if (last_bit) begin
            state_d = StFinish;
          end else begin
            state_d = StSckHi;
`ifdef SPI_CTRL_BYTE_GAP_EN
            if (cnt_q[2:0] == 3'd7) state_d = StGap;
`endif
          end
        end
      end
`ifdef SPI_CTRL_BYTE_GAP_EN
      StGap:    if (tick && gap_half_q) state_d = StSckHi;
`endif
      StFinish: if (tick) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_word_q  <= '0;
      done_q     <= 1'b0;
`ifdef SPI_CTRL_BYTE_GAP_EN
      gap_half_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (start_ok) begin
        tx_sr_q <= byte_swap(tx_word);
        rx_sr_q <= '0;
        cnt_q   <= '0;
      end
      if (tick) begin
        // Sample on the last SCK-high cycle; COPI advances as SCK falls.
        if (state_q == StSckHi) begin
          rx_sr_q <= {rx_sr_q[BITS-2:0], CIPO};
          tx_sr_q <= {tx_sr_q[BITS-2:0], CopiIdle};
        end
        if (state_q == StSckLo && !last_bit) cnt_q <= cnt_q + 1'b1;
        if (state_q == StFinish) begin
          done_q    <= 1'b1;
          rx_word_q <= byte_swap(rx_sr_q);
        end
`ifdef SPI_CTRL_BYTE_GAP_EN
        if (state_q == StGap) gap_half_q <= ~gap_half_q;
`endif
      end
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign rx_word = rx_word_q;
  assign CS      = busy ? ~CsIdle : CsIdle;
  assign SCK     = (state_q == StSckHi) ? ~SckIdle : SckIdle;
  assign COPI    = tx_sr_q[BITS-1];

endmodule

// File: tb/tb_spi_controller.sv
// Directed/randomized bench for spi_controller (BITS=64, CLKDIV=2) against a
// serial-order reference model.
module tb_spi_controller;

  localparam int unsigned BITS   = 64;
  localparam int unsigned CLKDIV = 2;
`ifdef SPI_CTRL_BYTE_GAP_EN
  localparam int unsigned CsLow = (2 * BITS + 2) * CLKDIV + (BITS / 8 - 1) * 2 * CLKDIV;
`else
  localparam int unsigned CsLow = (2 * BITS + 2) * CLKDIV;
`endif

  logic            clk = 1'b0;
  logic            resetn;
  logic            start;
  logic [BITS-1:0] tx_word;
  logic            busy, done, SCK, CS, COPI, CIPO;
  logic [BITS-1:0] rx_word;
  logic            cipo_r;
  int              mode;
  int              n_chk = 0;
  int              n_fail = 0;
  logic [BITS-1:0] last_rx;

  // mode 2 ties COPI back to CIPO
  assign CIPO = (mode == 2) ? COPI : cipo_r;

  spi_controller #(
    .BITS  (BITS),
    .CLKDIV(CLKDIV)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .tx_word(tx_word),
    .busy   (busy),
    .done   (done),
    .rx_word(rx_word),
    .SCK    (SCK),
    .CS     (CS),
    .COPI   (COPI),
    .CIPO   (CIPO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word bit position of the k-th serial bit: byte k/8, MSB-first within the byte.
  function automatic int word_pos(input int k);
    return 8 * (k / 8) + 7 - (k % 8);
  endfunction

  // m: 0 random CIPO, 1 CIPO=1, 2 loopback. poke_at/rst_at < 0 disable those events.
  task automatic run_xfer(input logic [63:0] tx, input int m, input int poke_at,
                          input int rst_at);
    logic [63:0] exp_rx;
    int          k, cs_low, bad;
    logic        sck_p, copi_p;
    bit          fin;
    mode   = m;
    cipo_r = (m == 1);
    exp_rx = '0;
    k      = 0;
    cs_low = 0;
    bad    = 0;
    sck_p  = 1'b0;
    copi_p = 1'b0;
    fin    = 0;
    @(negedge clk);
    tx_word = tx;
    start   = 1'b1;
    for (int c = 0; c < 4 * int'(CsLow) && !fin; c++) begin
      @(negedge clk);
      start = (c == poke_at);
      if (c == poke_at) tx_word = ~tx;
      if (c == rst_at) begin
        resetn = 1'b0;
        #1;
        check("rst_cs", CS, 1);
        check("rst_sck", SCK, 0);
        check("rst_copi", COPI, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx", rx_word, 0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int w = 0; w < int'(CsLow) + 20; w++) begin
          @(negedge clk);
          if (done || !CS) bad++;
        end
        check("rst_no_done_no_cs", bad, 0);
        last_rx = '0;
        return;
      end
      if (c == 0) begin
        check("cs_fall", CS, 0);
        check("busy_on", busy, 1);
        check("rx_held", rx_word, last_rx);
      end else if (!CS) begin
        check("copi_only_on_sck_fall", (COPI !== copi_p) && !(sck_p && !SCK), 1'b0);
      end
      if (m == 1 && !CS) check("copi_zero", COPI, 0);
      copi_p = COPI;
      if (!CS) cs_low++;
      if (SCK && !sck_p) begin
        if (k < int'(BITS)) begin
          check("copi_bit", COPI, tx[word_pos(k)]);
          exp_rx[word_pos(k)] = CIPO;
        end
        k++;
      end
      sck_p = SCK;
      if (m == 0 && !SCK) cipo_r = 1'($urandom);
      if (done) begin
        fin = 1;
        check("done_cs_high", CS, 1);
        check("done_busy_low", busy, 0);
        check("rx_model", rx_word, exp_rx);
        if (m == 2) check("rx_loopback", rx_word, tx);
        if (m == 1) check("rx_ones", rx_word, '1);
        check("cs_low_cycles", cs_low, CsLow);
        check("sck_rises", k, BITS);
        last_rx = exp_rx;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_single_pulse", done, 0);
        check("start_on_done_ignored", busy, 0);
        check("cs_idle", CS, 1);
      end
    end
    check("xfer_completed", fin, 1);
  endtask

  initial begin
    resetn  = 1'b0;
    start   = 1'b0;
    tx_word = '0;
    cipo_r  = 1'b0;
    mode    = 0;
    last_rx = '0;
    #1;
    check("reset_cs", CS, 1);
    check("reset_sck", SCK, 0);
    check("reset_copi", COPI, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rx", rx_word, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    run_xfer(64'h0123_4567_89AB_CDEF, 2, -1, -1);
    run_xfer(64'h0, 1, -1, -1);
    run_xfer({$urandom, 24'($urandom), 8'hA5}, 0, -1, -1);
    run_xfer({$urandom, $urandom}, 0, 10, -1);
    run_xfer({$urandom, $urandom}, 2, -1, 40);
    run_xfer({$urandom, $urandom}, 2, -1, -1);
    for (int i = 0; i < 3; i++) run_xfer({$urandom, $urandom}, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
